// File: rtl/eth_tx_backoff_ctrl.sv
// rtl/eth_tx_backoff_ctrl.sv - CSMA/CD transmit defer, gap, jam and backoff sequencer
module eth_tx_backoff_ctrl #(
   parameter int IPG_NIBBLES  = 24,
   parameter int SLOT_NIBBLES = 128,
   parameter int JAM_NIBBLES  = 8
) (
   input  logic       MTxClk,
   input  logic       Resetn,
   input  logic       TxStartReq,
   input  logic       TxFrameEnd,
   input  logic       CarrierSense,
   input  logic       Collision,
   input  logic [3:0] MaxRet,
   output logic       TxGo,
   output logic       StateJam,
   output logic       BackoffActive,
   output logic [3:0] RetryCnt,
   output logic       TxDone,
   output logic       TxRetry,
   output logic       TxAbort,
   output logic       LateColl
);

   // IPG and JAM never overlap, so they share one gap counter sized for the longer one
   localparam int GAP_MAX = (IPG_NIBBLES > JAM_NIBBLES) ? IPG_NIBBLES : JAM_NIBBLES;
   localparam int GW      = $clog2(GAP_MAX + 1);
   localparam int SW      = $clog2(SLOT_NIBBLES);

   localparam logic [GW-1:0] IPG_LAST  = GW'(IPG_NIBBLES - 1);
   localparam logic [GW-1:0] JAM_LAST  = GW'(JAM_NIBBLES - 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_NIBBLES - 1);
   localparam logic [15:0]   SLOT_LEN  = 16'(SLOT_NIBBLES);

   typedef enum logic [2:0] {
      IDLE,
      DEFER,
      IPG,
      XMIT,
      JAM,
      BACKOFF
   } state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
   logic [15:0]     nib_cnt_q, nib_cnt_d;
   logic            late_q, late_d;
   logic [3:0]      retry_cnt_q, retry_cnt_d;
   logic [9:0]      lfsr_q, lfsr_d;
   logic [SW-1:0]   bo_nib_q, bo_nib_d;
   logic [9:0]      bo_slot_q, bo_slot_d;
   logic [9:0]      bo_r_q, bo_r_d;
   logic            tx_done_q, tx_done_d;
   logic            tx_retry_q, tx_retry_d;
   logic            tx_abort_q, tx_abort_d;
   logic            late_coll_q, late_coll_d;

   logic [3:0]      retry_inc;
   logic [9:0]      backoff_mask;
   logic [9:0]      backoff_r;

   // Backoff window for the retry about to be scheduled, truncated at 10 bits
   always_comb begin
      retry_inc = retry_cnt_q + 4'd1;
      if (retry_inc >= 4'd10) begin
         backoff_mask = 10'h3FF;
      end else begin
         backoff_mask = (10'd1 << retry_inc) - 10'd1;
      end
      backoff_r = lfsr_q & backoff_mask;
   end

   // Next-state, counter and pulse logic for the attempt loop
   always_comb begin
      state_d     = state_q;
      gap_cnt_d   = gap_cnt_q;
      nib_cnt_d   = nib_cnt_q;
      late_d      = late_q;
      retry_cnt_d = retry_cnt_q;
      bo_nib_d    = bo_nib_q;
      bo_slot_d   = bo_slot_q;
      bo_r_d      = bo_r_q;
      tx_done_d   = 1'b0;
      tx_retry_d  = 1'b0;
      tx_abort_d  = 1'b0;
      late_coll_d = 1'b0;
      lfsr_d      = {lfsr_q[8:0], ~(lfsr_q[2] ^ lfsr_q[9])};

      case (state_q)
         IDLE: begin
            if (TxStartReq) begin
               state_d = DEFER;
            end
         end
         DEFER: begin
            if (!TxStartReq) begin
               state_d = IDLE;
            end else if (!CarrierSense) begin
               state_d   = IPG;
               gap_cnt_d = '0;
            end
         end
         IPG: begin
            if (CarrierSense) begin
               state_d = DEFER;
            end else if (!TxStartReq) begin
               state_d = IDLE;
            end else if (gap_cnt_q == IPG_LAST) begin
               state_d   = XMIT;
               nib_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         XMIT: begin
            if (Collision) begin
               state_d   = JAM;
               late_d    = (nib_cnt_q >= SLOT_LEN);
               gap_cnt_d = '0;
            end else if (TxFrameEnd) begin
               state_d     = IDLE;
               tx_done_d   = 1'b1;
               retry_cnt_d = 4'd0;
            end else if (nib_cnt_q != 16'hFFFF) begin
               nib_cnt_d = nib_cnt_q + 16'd1;
            end
         end
         JAM: begin
            if (gap_cnt_q == JAM_LAST) begin
               if (late_q) begin
                  state_d     = IDLE;
                  late_coll_d = 1'b1;
                  tx_abort_d  = 1'b1;
                  retry_cnt_d = 4'd0;
               end else if (retry_cnt_q == MaxRet) begin
                  state_d     = IDLE;
                  tx_abort_d  = 1'b1;
                  retry_cnt_d = 4'd0;
               end else begin
                  retry_cnt_d = retry_inc;
                  tx_retry_d  = 1'b1;
                  bo_r_d      = backoff_r;
                  bo_nib_d    = '0;
                  bo_slot_d   = 10'd0;
                  state_d     = (backoff_r == 10'd0) ? DEFER : BACKOFF;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         BACKOFF: begin
            if (bo_nib_q == SLOT_LAST) begin
               bo_nib_d = '0;
               if (bo_slot_q == bo_r_q - 10'd1) begin
                  state_d = DEFER;
               end else begin
                  bo_slot_d = bo_slot_q + 10'd1;
               end
            end else begin
               bo_nib_d = bo_nib_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counters, LFSR and pulse registers with asynchronous clear
   always_ff @(posedge MTxClk or negedge Resetn) begin
      if (!Resetn) begin
         state_q     <= IDLE;
         gap_cnt_q   <= '0;
         nib_cnt_q   <= '0;
         late_q      <= 1'b0;
         retry_cnt_q <= 4'd0;
         lfsr_q      <= 10'd0;
         bo_nib_q    <= '0;
         bo_slot_q   <= 10'd0;
         bo_r_q      <= 10'd0;
         tx_done_q   <= 1'b0;
         tx_retry_q  <= 1'b0;
         tx_abort_q  <= 1'b0;
         late_coll_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gap_cnt_q   <= gap_cnt_d;
         nib_cnt_q   <= nib_cnt_d;
         late_q      <= late_d;
         retry_cnt_q <= retry_cnt_d;
         lfsr_q      <= lfsr_d;
         bo_nib_q    <= bo_nib_d;
         bo_slot_q   <= bo_slot_d;
         bo_r_q      <= bo_r_d;
         tx_done_q   <= tx_done_d;
         tx_retry_q  <= tx_retry_d;
         tx_abort_q  <= tx_abort_d;
         late_coll_q <= late_coll_d;
      end
   end

   assign TxGo          = (state_q == XMIT);
   assign StateJam      = (state_q == JAM);
   assign BackoffActive = (state_q == BACKOFF);
   assign RetryCnt      = retry_cnt_q;
   assign TxDone        = tx_done_q;
   assign TxRetry       = tx_retry_q;
   assign TxAbort       = tx_abort_q;
   assign LateColl      = late_coll_q;

endmodule

// File: tb/tb_eth_tx_backoff_ctrl.sv
// tb/tb_eth_tx_backoff_ctrl.sv - directed bench with cycle-level behavioural model for eth_tx_backoff_ctrl
module tb_eth_tx_backoff_ctrl;

   localparam int IPG  = 24;
   localparam int SLOT = 128;
   localparam int JAM  = 8;

   localparam int P_IDLE = 0;
   localparam int P_WAIT = 1;
   localparam int P_GAP  = 2;
   localparam int P_SEND = 3;
   localparam int P_JAM  = 4;
   localparam int P_BACK = 5;

   logic       MTxClk;
   logic       Resetn;
   logic       TxStartReq;
   logic       TxFrameEnd;
   logic       CarrierSense;
   logic       Collision;
   logic [3:0] MaxRet;
   logic       TxGo;
   logic       StateJam;
   logic       BackoffActive;
   logic [3:0] RetryCnt;
   logic       TxDone;
   logic       TxRetry;
   logic       TxAbort;
   logic       LateColl;

   int total = 0;
   int bad   = 0;

   eth_tx_backoff_ctrl dut (
      .MTxClk        (MTxClk),
      .Resetn        (Resetn),
      .TxStartReq    (TxStartReq),
      .TxFrameEnd    (TxFrameEnd),
      .CarrierSense  (CarrierSense),
      .Collision     (Collision),
      .MaxRet        (MaxRet),
      .TxGo          (TxGo),
      .StateJam      (StateJam),
      .BackoffActive (BackoffActive),
      .RetryCnt      (RetryCnt),
      .TxDone        (TxDone),
      .TxRetry       (TxRetry),
      .TxAbort       (TxAbort),
      .LateColl      (LateColl)
   );

   initial MTxClk = 1'b0;
   always #5 MTxClk = ~MTxClk;

   // Model: phase plus a countdown of cycles left in it; backoff is one R*SLOT countdown
   typedef struct {
      int         ph;
      int         left;
      int         sent;
      bit         late;
      int         rc;
      logic [9:0] lfsr;
      bit         done;
      bit         retry;
      bit         abort;
      bit         latec;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t z;
      z.ph = P_IDLE; z.left = 0; z.sent = 0; z.late = 0; z.rc = 0; z.lfsr = 10'd0;
      z.done = 0; z.retry = 0; z.abort = 0; z.latec = 0;
      return z;
   endfunction

   function automatic model_t model_next(model_t c, logic req, logic fe, logic cs, logic col, int maxret);
      model_t n;
      int     r;
      int     w;
      n = c;
      n.done = 0; n.retry = 0; n.abort = 0; n.latec = 0;
      n.lfsr = {c.lfsr[8:0], ~(c.lfsr[2] ^ c.lfsr[9])};
      case (c.ph)
         P_IDLE: if (req) n.ph = P_WAIT;
         P_WAIT: begin
            if (!req) n.ph = P_IDLE;
            else if (!cs) begin n.ph = P_GAP; n.left = IPG; end
         end
         P_GAP: begin
            if (cs) n.ph = P_WAIT;
            else if (!req) n.ph = P_IDLE;
            else begin
               n.left = c.left - 1;
               if (n.left == 0) begin n.ph = P_SEND; n.sent = 0; end
            end
         end
         P_SEND: begin
            if (col) begin n.late = (c.sent >= SLOT); n.ph = P_JAM; n.left = JAM; end
            else if (fe) begin n.ph = P_IDLE; n.done = 1; n.rc = 0; end
            else n.sent = c.sent + 1;
         end
         P_JAM: begin
            n.left = c.left - 1;
            if (n.left == 0) begin
               if (c.late) begin n.ph = P_IDLE; n.latec = 1; n.abort = 1; n.rc = 0; end
               else if (c.rc == maxret) begin n.ph = P_IDLE; n.abort = 1; n.rc = 0; end
               else begin
                  n.rc    = c.rc + 1;
                  n.retry = 1;
                  w       = (n.rc > 10) ? 10 : n.rc;
                  r       = int'(c.lfsr) % (1 << w);
                  if (r == 0) n.ph = P_WAIT;
                  else begin n.ph = P_BACK; n.left = r * SLOT; end
               end
            end
         end
         P_BACK: begin
            n.left = c.left - 1;
            if (n.left == 0) n.ph = P_WAIT;
         end
         default: n.ph = P_IDLE;
      endcase
      return n;
   endfunction

   // Advance the model on every clock; reset clears it at once
   always @(posedge MTxClk or negedge Resetn) begin
      if (!Resetn) m <= model_reset();
      else         m <= model_next(m, TxStartReq, TxFrameEnd, CarrierSense, Collision, int'(MaxRet));
   end

   // Compare all outputs against the model on every falling edge
   initial begin
      logic [10:0] dut_v;
      logic [10:0] exp_v;
      forever begin
         @(negedge MTxClk);
         dut_v = {TxGo, StateJam, BackoffActive, RetryCnt, TxDone, TxRetry, TxAbort, LateColl};
         exp_v = {(m.ph == P_SEND), (m.ph == P_JAM), (m.ph == P_BACK), 4'(m.rc),
                  m.done, m.retry, m.abort, m.latec};
         total++;
         if (dut_v !== exp_v) begin
            bad++;
            $display("FAIL model_cycle t=%0t got go/jam/bo/rc/done/retry/abort/late=%b want=%b",
                     $time, dut_v, exp_v);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge MTxClk);
      #1;
   endtask

   task automatic steps(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic wait_go(output int n);
      n = 0;
      while (TxGo !== 1'b1 && n < 400) begin step(); n++; end
   endtask

   task automatic count_jam(output int n);
      n = 0;
      while (StateJam === 1'b1 && n < 100) begin step(); n++; end
   endtask

   task automatic count_bo(output int n);
      n = 0;
      while (BackoffActive === 1'b1 && n < 3000) begin step(); n++; end
   endtask

   // Called in the first XMIT cycle; returns in the first cycle after JAM
   task automatic collide_after(input int nib, output int jam_len);
      steps(nib);
      Collision = 1'b1;
      step();
      Collision = 1'b0;
      count_jam(jam_len);
   endtask

   task automatic finish_frame(input int nib, input string name);
      steps(nib);
      TxFrameEnd = 1'b1;
      step();
      TxFrameEnd = 1'b0;
      TxStartReq = 1'b0;
      chk({name, "_done"}, TxDone, 1);
      chk({name, "_rc"}, RetryCnt, 0);
   endtask

   initial begin
      int n;
      int j;
      int got;
      Resetn = 1'b0; TxStartReq = 1'b0; TxFrameEnd = 1'b0;
      CarrierSense = 1'b0; Collision = 1'b0; MaxRet = 4'd15;
      steps(3);
      chk("reset_state", {TxGo, StateJam, BackoffActive, RetryCnt, TxDone, TxRetry, TxAbort, LateColl}, 0);
      Resetn = 1'b1;
      step();

      // Clean frame
      TxStartReq = 1'b1;
      wait_go(n);
      chk("grant_latency", n, 26);
      steps(100);
      TxFrameEnd = 1'b1;
      step();
      TxFrameEnd = 1'b0;
      TxStartReq = 1'b0;
      chk("clean_done", TxDone, 1);
      chk("clean_txgo_low", TxGo, 0);
      chk("clean_rc", RetryCnt, 0);
      step();
      chk("clean_done_once", TxDone, 0);

      // Early collision then retry
      step();
      TxStartReq = 1'b1;
      wait_go(n);
      collide_after(20, j);
      chk("early_jam_len", j, 8);
      chk("early_retry", TxRetry, 1);
      chk("early_rc", RetryCnt, 1);
      count_bo(n);
      chk("early_bo_mult", n % SLOT, 0);
      chk("early_bo_bound", int'(n / SLOT < 2), 1);
      wait_go(n);
      chk("early_regrant", n, 25);
      finish_frame(10, "early");

      // Retry limit
      MaxRet = 4'd2;
      step();
      TxStartReq = 1'b1;
      for (int a = 0; a < 3; a++) begin
         wait_go(n);
         chk("limit_go", TxGo, 1);
         collide_after(5, j);
         chk("limit_jam_len", j, 8);
         if (a < 2) begin
            chk("limit_retry", TxRetry, 1);
            chk("limit_rc", RetryCnt, a + 1);
            count_bo(n);
            chk("limit_bo_mult", n % SLOT, 0);
            chk("limit_bo_bound", int'(n / SLOT < (1 << (a + 1))), 1);
         end else begin
            chk("limit_abort", TxAbort, 1);
            chk("limit_no_retry", TxRetry, 0);
            chk("limit_rc_clear", RetryCnt, 0);
            chk("limit_no_bo", BackoffActive, 0);
            TxStartReq = 1'b0;
         end
      end
      step();
      chk("limit_idle_no_bo", BackoffActive, 0);
      MaxRet = 4'd15;

      // Late collision, after one in-window retry
      step();
      TxStartReq = 1'b1;
      wait_go(n);
      collide_after(3, j);
      count_bo(n);
      wait_go(n);
      steps(128);
      Collision = 1'b1;
      step();
      Collision = 1'b0;
      chk("late_rc_held", RetryCnt, 1);
      count_jam(j);
      chk("late_jam_len", j, 8);
      chk("late_collpulse", LateColl, 1);
      chk("late_abort", TxAbort, 1);
      chk("late_no_retry", TxRetry, 0);
      chk("late_rc_clear", RetryCnt, 0);
      chk("late_no_bo", BackoffActive, 0);
      TxStartReq = 1'b0;
      step();
      chk("late_pulse_once", LateColl, 0);

      // Boundary: NibCnt=127 is still in the window
      step();
      TxStartReq = 1'b1;
      wait_go(n);
      collide_after(127, j);
      chk("edge127_retry", TxRetry, 1);
      chk("edge127_not_late", LateColl, 0);
      chk("edge127_no_abort", TxAbort, 0);
      chk("edge127_rc", RetryCnt, 1);
      count_bo(n);
      wait_go(n);
      finish_frame(4, "edge127");

      // Carrier during the gap restarts the full gap
      step();
      TxStartReq = 1'b1;
      steps(2);
      steps(10);
      CarrierSense = 1'b1;
      steps(5);
      chk("cs_no_go", TxGo, 0);
      CarrierSense = 1'b0;
      wait_go(n);
      chk("cs_regrant", n, 25);
      finish_frame(2, "cs");

      // Cancel from DEFER
      step();
      TxStartReq = 1'b1;
      CarrierSense = 1'b1;
      steps(3);
      TxStartReq = 1'b0;
      step();
      chk("cancel_quiet", {TxGo, TxDone, TxRetry, TxAbort, LateColl}, 0);
      CarrierSense = 1'b0;
      steps(3);
      chk("cancel_no_go", TxGo, 0);

      // Reset in the middle of a backoff
      step();
      TxStartReq = 1'b1;
      got = 0;
      for (int a = 0; a < 15 && got == 0; a++) begin
         wait_go(n);
         collide_after(2, j);
         if (BackoffActive === 1'b1) got = 1;
      end
      chk("reached_backoff", got, 1);
      steps(5);
      #2;
      Resetn = 1'b0;
      TxStartReq = 1'b0;
      #1;
      chk("rst_bo", BackoffActive, 0);
      chk("rst_rc", RetryCnt, 0);
      chk("rst_all", {TxGo, StateJam, BackoffActive, RetryCnt, TxDone, TxRetry, TxAbort, LateColl}, 0);
      steps(2);
      Resetn = 1'b1;
      TxStartReq = 1'b1;
      wait_go(n);
      chk("rst_grant_latency", n, 26);
      finish_frame(3, "rst");
      steps(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
